// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, ERR} dmem_state_t;

  typedef enum logic {OP_RD, OP_WR} dmem_op_t;

  localparam int LINE_WORDS_DEF = 4;
  localparam int BEAT_W         = $clog2(LINE_WORDS_DEF);
  localparam int LAT_W          = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - data-cache to memory request/response bus
interface data_mem_responder_if #(
  parameter int N = 8
);

  logic [N-1:0] A;
  logic         RE;
  logic         WE;
  logic         BURST;
  logic [N-1:0] WD;
  logic [N-1:0] RD;
  logic         RVALID;
  logic         WACK;
  logic         BUSY;
  logic         IOException;

  modport master (
    output A, RE, WE, BURST, WD,
    input  RD, RVALID, WACK, BUSY, IOException
  );

  modport slave (
    input  A, RE, WE, BURST, WD,
    output RD, RVALID, WACK, BUSY, IOException
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word RAM behind the responder
module dmem_array #(
  parameter int N         = 8,
  parameter int MEM_WORDS = 192
) (
  input  logic         clk,
  input  logic         we,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wd,
  output logic [N-1:0] rd
);

  logic [N-1:0] mem [MEM_WORDS];
  logic         in_range;

  // Addresses past the window (e.g. prefetch after a line's last beat) read as zero.
  assign in_range = int'(addr) < MEM_WORDS;

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr] <= wd;
    end
    rd <= in_range ? mem[addr] : '0;
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - latency-programmable responder for single, write and line-fill requests
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int N          = 8,
  parameter int MEM_WORDS  = 192,
  parameter int LINE_WORDS = 1 << BEAT_W,
  parameter int LATENCY    = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  data_mem_responder_if.slave  bus
);

  localparam int           BW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [N-1:0] ALIGN_MASK = ~N'(LINE_WORDS - 1);

  dmem_state_t     state_q, state_d;
  dmem_op_t        op_q, op_d;
  logic            burst_q, burst_d;
  logic [N-1:0]    addr_q, addr_d;
  logic [N-1:0]    wd_q, wd_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [BW-1:0]   beat_q, beat_d;

  logic            req;
  logic            req_burst;
  logic [N-1:0]    req_addr;
  logic            last_beat;
  logic            xfer_done;
  logic [N-1:0]    mem_addr;
  logic            mem_we;
  logic [N-1:0]    mem_rd;

  assign req       = bus.RE | bus.WE;
  assign req_burst = bus.BURST & ~bus.WE;
  assign req_addr  = req_burst ? (bus.A & ALIGN_MASK) : bus.A;
  assign last_beat = !burst_q || (beat_q == BW'(LINE_WORDS - 1));
  assign xfer_done = (op_q == OP_WR) || last_beat;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          op_d    = bus.WE ? OP_WR : OP_RD;
          burst_d = req_burst;
          addr_d  = req_addr;
          wd_d    = bus.WD;
          beat_d  = '0;
          if (int'(bus.A) >= MEM_WORDS) begin
            state_d = ERR;
          end else if (LATENCY > 0) begin
            state_d = WAIT;
            lat_d   = LAT_W'(LATENCY - 1);
          end else begin
            state_d = XFER;
          end
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = XFER;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      XFER: begin
        if (xfer_done) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The RAM is one cycle behind, so each cycle presents the address of the next beat.
  always_comb begin
    mem_addr = addr_q;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: mem_addr = req_addr;
      XFER: begin
        if (op_q == OP_WR) begin
          mem_we = 1'b1;
        end else begin
          mem_addr = addr_q + N'(beat_q) + N'(1);
        end
      end
      default: mem_addr = addr_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      burst_q <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      lat_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
    end
  end

  dmem_array #(
    .N         (N),
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .clk  (CLK),
    .we   (mem_we),
    .addr (mem_addr),
    .wd   (wd_q),
    .rd   (mem_rd)
  );

  // The response cycle (last beat, WACK or error) drops BUSY so the initiator advances.
  assign bus.BUSY = (state_q == IDLE) ? req :
                    (state_q == WAIT) ? 1'b1 :
                    (state_q == XFER) ? !xfer_done : 1'b0;

  assign bus.RVALID      = ((state_q == XFER) || (state_q == ERR)) && (op_q == OP_RD);
  assign bus.WACK        = ((state_q == XFER) || (state_q == ERR)) && (op_q == OP_WR);
  assign bus.RD          = ((state_q == XFER) && (op_q == OP_RD)) ? mem_rd : '0;
  assign bus.IOException = (state_q == ERR);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench for data_mem_responder at LATENCY 2 and 0
module tb_data_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, wd;
  logic       re, we, burst;
  logic       lat0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.N(8)) if2 ();
  data_mem_responder_if #(.N(8)) if0 ();

  assign if2.A = a;  assign if2.WD = wd;  assign if2.BURST = burst;
  assign if2.RE = re & ~lat0;  assign if2.WE = we & ~lat0;
  assign if0.A = a;  assign if0.WD = wd;  assign if0.BURST = burst;
  assign if0.RE = re & lat0;   assign if0.WE = we & lat0;

  data_mem_responder #(.N(8), .MEM_WORDS(192), .LINE_WORDS(4), .LATENCY(2)) dut2 (
    .CLK(clk), .RESET(rst), .bus(if2)
  );
  data_mem_responder #(.N(8), .MEM_WORDS(192), .LINE_WORDS(4), .LATENCY(0)) dut0 (
    .CLK(clk), .RESET(rst), .bus(if0)
  );

  logic [7:0] rd_o;
  logic       rvalid_o, wack_o, busy_o, iox_o;
  assign rd_o     = lat0 ? if0.RD : if2.RD;
  assign rvalid_o = lat0 ? if0.RVALID : if2.RVALID;
  assign wack_o   = lat0 ? if0.WACK : if2.WACK;
  assign busy_o   = lat0 ? if0.BUSY : if2.BUSY;
  assign iox_o    = lat0 ? if0.IOException : if2.IOException;

  logic [7:0] mdl [2][256];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic go_idle();
    re = 1'b0; we = 1'b0; burst = 1'b0;
    @(negedge clk);
    check("busy_idle", busy_o, 1'b0);
    check("rvalid_idle", rvalid_o, 1'b0);
    @(posedge clk); #1;
  endtask

  // One request from its accept cycle through its last response cycle.
  task automatic do_txn(input logic w, input logic r, input logic b,
                        input logic [7:0] ad, input logic [7:0] d);
    int lat, first, nb, k;
    logic err;
    logic [7:0] base;
    lat   = lat0 ? 0 : 2;
    err   = (ad >= 8'd192);
    base  = (!w && b) ? (ad & 8'hFC) : ad;
    nb    = (!w && b && !err) ? 4 : 1;
    first = err ? 1 : lat + 1;
    a = ad; wd = d; we = w; re = r; burst = b;
    for (int c = 0; c < first + nb; c++) begin
      @(negedge clk);
      if (c < first) begin
        check("busy_pending", busy_o, 1'b1);
        check("rvalid_pending", rvalid_o, 1'b0);
        check("wack_pending", wack_o, 1'b0);
        check("iox_pending", iox_o, 1'b0);
      end else if (err) begin
        check("iox_err", iox_o, 1'b1);
        check("busy_err", busy_o, 1'b0);
        check("rvalid_err", rvalid_o, !w);
        check("wack_err", wack_o, w);
        check("rd_err", rd_o, 8'h00);
      end else if (w) begin
        check("wack", wack_o, 1'b1);
        check("rvalid_on_write", rvalid_o, 1'b0);
        check("busy_wack", busy_o, 1'b0);
        check("iox_write", iox_o, 1'b0);
        mdl[lat0][ad] = d;
      end else begin
        k = c - first;
        check("rvalid", rvalid_o, 1'b1);
        check("rd", rd_o, mdl[lat0][base + 8'(k)]);
        check("busy_beat", busy_o, k != nb - 1);
        check("wack_on_read", wack_o, 1'b0);
        check("iox_read", iox_o, 1'b0);
      end
      @(posedge clk); #1;
      if (c < first + nb - 1) begin
        a  = 8'($urandom);
        wd = 8'($urandom);
      end
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 192; i++) begin
      do_txn(1'b1, 1'b0, 1'b0, 8'(i), 8'($urandom));
    end
    go_idle();
  endtask

  task automatic random_txns(input int count);
    int kind;
    logic [7:0] ad, d;
    for (int i = 0; i < count; i++) begin
      kind = $urandom_range(0, 4);
      ad   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(192, 255)) : 8'($urandom_range(0, 191));
      d    = 8'($urandom);
      case (kind)
        0:       do_txn(1'b1, 1'b0, 1'b0, ad, d);
        1:       do_txn(1'b0, 1'b1, 1'b0, ad, d);
        2:       do_txn(1'b0, 1'b1, 1'b1, ad, d);
        3:       do_txn(1'b1, 1'b1, 1'b0, ad, d);
        default: do_txn(1'b1, 1'b0, 1'b1, ad, d);
      endcase
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
  endtask

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; burst = 1'b0; a = '0; wd = '0; lat0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      lat0 = s[0];
      @(negedge clk);
      check("rst_rvalid", rvalid_o, 1'b0);
      check("rst_wack", wack_o, 1'b0);
      check("rst_iox", iox_o, 1'b0);
      check("rst_rd", rd_o, 8'h00);
      check("rst_busy", busy_o, 1'b0);
    end
    @(posedge clk); #1;

    lat0 = 1'b0;
    preload();
    do_txn(1'b1, 1'b0, 1'b0, 8'h10, 8'h5A);
    do_txn(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    check("model_5a", mdl[0][8'h10], 8'h5A);
    do_txn(1'b1, 1'b0, 1'b0, 8'h20, 8'h11);
    do_txn(1'b1, 1'b0, 1'b0, 8'h21, 8'h22);
    do_txn(1'b1, 1'b0, 1'b0, 8'h22, 8'h33);
    do_txn(1'b1, 1'b0, 1'b0, 8'h23, 8'h44);
    do_txn(1'b0, 1'b1, 1'b1, 8'h22, 8'h00);
    do_txn(1'b0, 1'b1, 1'b0, 8'hC8, 8'h00);
    do_txn(1'b1, 1'b0, 1'b0, 8'hF0, 8'h99);
    do_txn(1'b0, 1'b1, 1'b0, 8'hF0, 8'h00);
    do_txn(1'b1, 1'b1, 1'b0, 8'h05, 8'h77);
    do_txn(1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
    go_idle();

    // Burst of 0x22 aborted by reset during its second beat.
    a = 8'h22; re = 1'b1; we = 1'b0; burst = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("abort_beat2_rvalid", rvalid_o, 1'b1);
    check("abort_beat2_rd", rd_o, 8'h22);
    @(posedge clk); #1;
    rst = 1'b0; re = 1'b0; burst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_rvalid", rvalid_o, 1'b0);
      check("abort_busy", busy_o, 1'b0);
      check("abort_iox", iox_o, 1'b0);
      @(posedge clk); #1;
    end
    do_txn(1'b0, 1'b1, 1'b0, 8'h21, 8'h00);
    go_idle();
    random_txns(150);

    lat0 = 1'b1;
    preload();
    for (int i = 0; i < 8; i++) begin
      do_txn(1'b1, 1'b0, 1'b0, 8'h30, 8'($urandom));
      do_txn(1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
    end
    do_txn(1'b0, 1'b1, 1'b1, 8'hBF, 8'h00);
    do_txn(1'b0, 1'b1, 1'b0, 8'hC0, 8'h00);
    go_idle();
    random_txns(150);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
